// File: rtl/renew_request_dispatcher.sv
// ============================================================================
// renew_request_dispatcher
// ----------------------------------------------------------------------------
// Issue-side front end of the multi-processor manager. Accepts one decoded
// register-renew request at a time, holds it until none of its registers is
// busy in the register manager's table, selects processor 1 or 2, fires a
// single-cycle boot pulse and then waits for the chosen processor to leave
// idle. Barrier requests instead wait for both processors to be synchronized
// and idle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_sync                   barrier request, no boot issued
//   req_three                  1 = three destinations, 0 = rd1 only
//   req_rd                     destinations {rd3, rd2, rd1}
//   req_rs1, req_rs2           source registers
//   processor_idle_1/_2        processor idle flags
//   processing_register_table  busy-register mask from the register manager
//   synchronized_processors    both processors synchronized
//   boot_renew_register_1      single-register boot to processor 1 (pulse)
//   boot_renew_register_2      single-register boot to processor 2 (pulse)
//   boot_renew_3registers_2    three-register boot to processor 2 (pulse)
//   register_num               destinations of the last captured request
//   issue_target               0 = processor 1, 1 = processor 2 (last issue)
//   barrier_done               pulse when a barrier completes
//   timeout_err                pulse when the target never left idle
// ============================================================================
module renew_request_dispatcher #(
   parameter int REGISTER_AMOUNT = 32,
   parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
   parameter int ACCEPT_TIMEOUT  = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_sync,
   input  logic                         req_three,
   input  logic [REG_CTN_WIDTH*3-1:0]   req_rd,
   input  logic [REG_CTN_WIDTH-1:0]     req_rs1,
   input  logic [REG_CTN_WIDTH-1:0]     req_rs2,
   input  logic                         processor_idle_1,
   input  logic                         processor_idle_2,
   input  logic [0:REGISTER_AMOUNT-1]   processing_register_table,
   input  logic                         synchronized_processors,
   output logic                         boot_renew_register_1,
   output logic                         boot_renew_register_2,
   output logic                         boot_renew_3registers_2,
   output logic [REG_CTN_WIDTH*3-1:0]   register_num,
   output logic                         issue_target,
   output logic                         barrier_done,
   output logic                         timeout_err
);

   localparam int CNT_WIDTH = $clog2(ACCEPT_TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(ACCEPT_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CHECK       = 3'd1,
      ST_ISSUE       = 3'd2,
      ST_WAIT_ACCEPT = 3'd3,
      ST_BARRIER     = 3'd4
   } state_t;

   // Register 0 is hard-wired and can never be busy.
   function automatic logic reg_busy(input logic [0:REGISTER_AMOUNT-1] tbl,
                                     input logic [REG_CTN_WIDTH-1:0]   idx);
      if (idx == {REG_CTN_WIDTH{1'b0}}) begin
         reg_busy = 1'b0;
      end else begin
         reg_busy = tbl[idx];
      end
   endfunction

   state_t                        state_q, state_d;
   logic                          req_ready_q, req_ready_d;
   logic                          three_q, three_d;
   logic [REG_CTN_WIDTH-1:0]      rs1_q, rs1_d;
   logic [REG_CTN_WIDTH-1:0]      rs2_q, rs2_d;
   logic [REG_CTN_WIDTH*3-1:0]    register_num_q, register_num_d;
   logic                          issue_target_q, issue_target_d;
   logic                          boot_1_q, boot_1_d;
   logic                          boot_2_q, boot_2_d;
   logic                          boot_3_q, boot_3_d;
   logic                          barrier_done_q, barrier_done_d;
   logic                          timeout_err_q, timeout_err_d;
   logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;

   logic                          hazard_s;
   logic                          target_idle_s;
   logic [CNT_WIDTH-1:0]          cnt_inc_s;

   // Next-state, capture buffers and boot/pulse decisions.
   always_comb begin
      state_d        = state_q;
      three_d        = three_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      register_num_d = register_num_q;
      issue_target_d = issue_target_q;
      boot_1_d       = 1'b0;
      boot_2_d       = 1'b0;
      boot_3_d       = 1'b0;
      barrier_done_d = 1'b0;
      timeout_err_d  = 1'b0;
      cnt_d          = cnt_q;

      // rd2/rd3 only matter for three-destination requests.
      hazard_s = reg_busy(processing_register_table, rs1_q)
               | reg_busy(processing_register_table, rs2_q)
               | reg_busy(processing_register_table, register_num_q[REG_CTN_WIDTH-1:0])
               | (three_q & (reg_busy(processing_register_table,
                                      register_num_q[2*REG_CTN_WIDTH-1:REG_CTN_WIDTH])
                           | reg_busy(processing_register_table,
                                      register_num_q[3*REG_CTN_WIDTH-1:2*REG_CTN_WIDTH])));
      target_idle_s = issue_target_q ? processor_idle_2 : processor_idle_1;
      cnt_inc_s     = cnt_q + CNT_ONE;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               three_d        = req_three;
               rs1_d          = req_rs1;
               rs2_d          = req_rs2;
               register_num_d = req_rd;
               state_d        = req_sync ? ST_BARRIER : ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         // Boot flops are set on the way into ISSUE so the pulse is
         // registered and coincides with the ISSUE cycle.
         ST_CHECK: begin
            if (hazard_s) begin
               state_d = ST_CHECK;
            end else if (three_q) begin
               if (processor_idle_2) begin
                  issue_target_d = 1'b1;
                  boot_3_d       = 1'b1;
                  state_d        = ST_ISSUE;
               end else begin
                  state_d = ST_CHECK;
               end
            end else if (processor_idle_1) begin
               issue_target_d = 1'b0;
               boot_1_d       = 1'b1;
               state_d        = ST_ISSUE;
            end else if (processor_idle_2) begin
               issue_target_d = 1'b1;
               boot_2_d       = 1'b1;
               state_d        = ST_ISSUE;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_ISSUE: begin
            cnt_d   = {CNT_WIDTH{1'b0}};
            state_d = ST_WAIT_ACCEPT;
         end
         ST_WAIT_ACCEPT: begin
            if (!target_idle_s) begin
               state_d = ST_IDLE;
            end else if (cnt_inc_s == TIMEOUT_VAL) begin
               // Counter saturates at the limit; the request is dropped.
               cnt_d         = cnt_inc_s;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d   = cnt_inc_s;
               state_d = ST_WAIT_ACCEPT;
            end
         end
         ST_BARRIER: begin
            if (synchronized_processors && processor_idle_1 && processor_idle_2) begin
               barrier_done_d = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               state_d = ST_BARRIER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         req_ready_q    <= 1'b1;
         three_q        <= 1'b0;
         rs1_q          <= {REG_CTN_WIDTH{1'b0}};
         rs2_q          <= {REG_CTN_WIDTH{1'b0}};
         register_num_q <= {(REG_CTN_WIDTH*3){1'b0}};
         issue_target_q <= 1'b0;
         boot_1_q       <= 1'b0;
         boot_2_q       <= 1'b0;
         boot_3_q       <= 1'b0;
         barrier_done_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         cnt_q          <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         three_q        <= three_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         register_num_q <= register_num_d;
         issue_target_q <= issue_target_d;
         boot_1_q       <= boot_1_d;
         boot_2_q       <= boot_2_d;
         boot_3_q       <= boot_3_d;
         barrier_done_q <= barrier_done_d;
         timeout_err_q  <= timeout_err_d;
         cnt_q          <= cnt_d;
      end
   end

   assign req_ready               = req_ready_q;
   assign register_num            = register_num_q;
   assign issue_target            = issue_target_q;
   assign boot_renew_register_1   = boot_1_q;
   assign boot_renew_register_2   = boot_2_q;
   assign boot_renew_3registers_2 = boot_3_q;
   assign barrier_done            = barrier_done_q;
   assign timeout_err             = timeout_err_q;

endmodule

// File: tb/tb_renew_request_dispatcher.sv
// Scoreboard bench for renew_request_dispatcher: stimulus pushes expected
// output events (kind, cycle, register_num, issue_target); a monitor pops
// and compares whenever any pulse output is high.
module tb_renew_request_dispatcher;

   localparam int RA = 32;
   localparam int W  = 5;

   localparam logic [4:0] EV_B1 = 5'b10000;
   localparam logic [4:0] EV_B2 = 5'b01000;
   localparam logic [4:0] EV_B3 = 5'b00100;
   localparam logic [4:0] EV_BD = 5'b00010;
   localparam logic [4:0] EV_TO = 5'b00001;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req_valid, req_ready, req_sync, req_three;
   logic [W*3-1:0]  req_rd;
   logic [W-1:0]    req_rs1, req_rs2;
   logic            processor_idle_1, processor_idle_2;
   logic [0:RA-1]   processing_register_table;
   logic            synchronized_processors;
   logic            boot_renew_register_1, boot_renew_register_2, boot_renew_3registers_2;
   logic [W*3-1:0]  register_num;
   logic            issue_target, barrier_done, timeout_err;

   renew_request_dispatcher #(.REGISTER_AMOUNT(RA), .REG_CTN_WIDTH(W), .ACCEPT_TIMEOUT(15)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .req_valid                 (req_valid),
      .req_ready                 (req_ready),
      .req_sync                  (req_sync),
      .req_three                 (req_three),
      .req_rd                    (req_rd),
      .req_rs1                   (req_rs1),
      .req_rs2                   (req_rs2),
      .processor_idle_1          (processor_idle_1),
      .processor_idle_2          (processor_idle_2),
      .processing_register_table (processing_register_table),
      .synchronized_processors   (synchronized_processors),
      .boot_renew_register_1     (boot_renew_register_1),
      .boot_renew_register_2     (boot_renew_register_2),
      .boot_renew_3registers_2   (boot_renew_3registers_2),
      .register_num              (register_num),
      .issue_target              (issue_target),
      .barrier_done              (barrier_done),
      .timeout_err               (timeout_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0]     ev;
      logic [W*3-1:0] rn;
      logic           tgt;
      int unsigned    at;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic expect_ev(input logic [4:0] ev, input logic [W*3-1:0] rn,
                            input logic tgt, input int unsigned at);
      exp_t e;
      e.ev = ev; e.rn = rn; e.tgt = tgt; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) @(negedge clk);
   endtask

   // Called at a negedge while the dispatcher is idle; hs = handshake cycle.
   task automatic do_req(input logic sync, input logic three, input logic [W*3-1:0] rd,
                         input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                         output int unsigned hs);
      chk("req_ready_before_req", {31'd0, req_ready}, 32'd1);
      req_sync  = sync;
      req_three = three;
      req_rd    = rd;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_valid = 1'b1;
      hs        = cyc;
   endtask

   // Monitor: every cycle with a pulse output high consumes one expectation.
   always @(negedge clk) begin
      logic [4:0] ev;
      exp_t       e;
      ev = {boot_renew_register_1, boot_renew_register_2, boot_renew_3registers_2,
            barrier_done, timeout_err};
      if (ev != 5'b00000) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_event: got %b at cycle %0d, expected none", ev, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind",   {27'd0, ev}, {27'd0, e.ev});
            chk("event_cycle",  cyc, e.at);
            chk("register_num", {17'd0, register_num}, {17'd0, e.rn});
            chk("issue_target", {31'd0, issue_target}, {31'd0, e.tgt});
         end
      end
   end

   initial begin
      int unsigned hs;
      rst_n = 1'b0;
      req_valid = 1'b0; req_sync = 1'b0; req_three = 1'b0;
      req_rd = '0; req_rs1 = '0; req_rs2 = '0;
      processor_idle_1 = 1'b1; processor_idle_2 = 1'b1;
      processing_register_table = '0;
      synchronized_processors = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_req_ready",    {31'd0, req_ready}, 32'd1);
      chk("rst_boot_outputs", {29'd0, boot_renew_register_1, boot_renew_register_2,
                               boot_renew_3registers_2}, 32'd0);
      chk("rst_pulses",       {30'd0, barrier_done, timeout_err}, 32'd0);
      chk("rst_register_num", {17'd0, register_num}, 32'd0);
      chk("rst_issue_target", {31'd0, issue_target}, 32'd0);
      @(negedge clk);

      // T1: single-dest to P1, valid held with changing data after capture
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd5}, 5'd2, 5'd3, hs);
      expect_ev(EV_B1, {5'd0, 5'd0, 5'd5}, 1'b0, hs + 2);
      @(negedge clk);
      req_rd = {5'd0, 5'd0, 5'd31};
      wait_cyc(hs + 3);
      chk("t1_ready_in_wait", {31'd0, req_ready}, 32'd0);
      processor_idle_1 = 1'b0;
      req_valid = 1'b0;
      wait_cyc(hs + 4);
      chk("t1_ready_back", {31'd0, req_ready}, 32'd1);
      chk("t1_regnum_held", {17'd0, register_num}, 32'd5);
      processor_idle_1 = 1'b1;

      // T2: P1 busy, P2 idle -> boot to P2
      processor_idle_1 = 1'b0;
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd12}, 5'd2, 5'd3, hs);
      expect_ev(EV_B2, {5'd0, 5'd0, 5'd12}, 1'b1, hs + 2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 3);
      processor_idle_2 = 1'b0;
      wait_cyc(hs + 4);
      chk("t2_ready_back", {31'd0, req_ready}, 32'd1);
      processor_idle_1 = 1'b1;
      processor_idle_2 = 1'b1;

      // T2b: single-dest ignores a busy rd2 field
      processing_register_table[6] = 1'b1;
      do_req(1'b0, 1'b0, {5'd0, 5'd6, 5'd5}, 5'd1, 5'd2, hs);
      expect_ev(EV_B1, {5'd0, 5'd6, 5'd5}, 1'b0, hs + 2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 3);
      processor_idle_1 = 1'b0;
      wait_cyc(hs + 4);
      processor_idle_1 = 1'b1;
      processing_register_table[6] = 1'b0;

      // T3: three-dest, rd2 busy for 10 cycles
      processing_register_table[8] = 1'b1;
      do_req(1'b0, 1'b1, {5'd9, 5'd8, 5'd7}, 5'd1, 5'd2, hs);
      expect_ev(EV_B3, {5'd9, 5'd8, 5'd7}, 1'b1, hs + 11);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 5);
      chk("t3_ready_stalled", {31'd0, req_ready}, 32'd0);
      wait_cyc(hs + 10);
      processing_register_table[8] = 1'b0;
      wait_cyc(hs + 12);
      processor_idle_2 = 1'b0;
      wait_cyc(hs + 13);
      chk("t3_ready_back", {31'd0, req_ready}, 32'd1);
      processor_idle_2 = 1'b1;

      // T4a: rs1=4 busy stalls until cleared
      processing_register_table[4] = 1'b1;
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd3}, 5'd4, 5'd2, hs);
      expect_ev(EV_B1, {5'd0, 5'd0, 5'd3}, 1'b0, hs + 6);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 5);
      processing_register_table[4] = 1'b0;
      wait_cyc(hs + 7);
      processor_idle_1 = 1'b0;
      wait_cyc(hs + 8);
      processor_idle_1 = 1'b1;

      // T4b: rs1=0 with bit 0 set issues at once; idle drops during ISSUE
      processing_register_table[0] = 1'b1;
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd3}, 5'd0, 5'd2, hs);
      expect_ev(EV_B1, {5'd0, 5'd0, 5'd3}, 1'b0, hs + 2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 2);
      processor_idle_1 = 1'b0;
      wait_cyc(hs + 3);
      chk("t4b_ready_in_wait", {31'd0, req_ready}, 32'd0);
      wait_cyc(hs + 4);
      chk("t4b_ready_back", {31'd0, req_ready}, 32'd1);
      processor_idle_1 = 1'b1;
      processing_register_table[0] = 1'b0;

      // T5: P1 never leaves idle -> timeout 15 cycles after WAIT_ACCEPT entry
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd17}, 5'd1, 5'd2, hs);
      expect_ev(EV_B1, {5'd0, 5'd0, 5'd17}, 1'b0, hs + 2);
      expect_ev(EV_TO, {5'd0, 5'd0, 5'd17}, 1'b0, hs + 18);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 17);
      chk("t5_ready_before_to", {31'd0, req_ready}, 32'd0);
      wait_cyc(hs + 18);
      chk("t5_ready_after_to", {31'd0, req_ready}, 32'd1);

      // T6: barrier waits 6 cycles for synchronization
      do_req(1'b1, 1'b0, {5'd0, 5'd0, 5'd0}, 5'd0, 5'd0, hs);
      expect_ev(EV_BD, {5'd0, 5'd0, 5'd0}, 1'b0, hs + 7);
      @(negedge clk);
      req_valid = 1'b0;
      req_sync  = 1'b0;
      wait_cyc(hs + 6);
      chk("t6_ready_in_barrier", {31'd0, req_ready}, 32'd0);
      synchronized_processors = 1'b1;
      wait_cyc(hs + 7);
      chk("t6_ready_back", {31'd0, req_ready}, 32'd1);
      synchronized_processors = 1'b0;
      @(negedge clk);

      // T7: reset while the boot pulse is high
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd21}, 5'd1, 5'd2, hs);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t7_boot_before_rst", {31'd0, boot_renew_register_1}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t7_boot_async_clear", {31'd0, boot_renew_register_1}, 32'd0);
      chk("t7_ready_async",      {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("t7_regnum_reset", {17'd0, register_num}, 32'd0);
      @(negedge clk);

      // T8: recovery after reset
      do_req(1'b0, 1'b0, {5'd0, 5'd0, 5'd11}, 5'd1, 5'd2, hs);
      expect_ev(EV_B1, {5'd0, 5'd0, 5'd11}, 1'b0, hs + 2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc(hs + 3);
      processor_idle_1 = 1'b0;
      wait_cyc(hs + 4);
      processor_idle_1 = 1'b1;

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
